// File: rtl/iram_pkg.sv
// Shared IRAM constants and loader state encoding.
// Imported by the boot loader, the IRAM and core decode.
package iram_pkg;

  localparam int IRAM_DEPTH_WORDS = 128;
  localparam int IRAM_ADDR_W = 8;
  localparam logic [15:0] IRAM_NOP_WORD = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_HI = 3'd1,
    ST_LOAD_LO = 3'd2,
    ST_WRITE   = 3'd3,
    ST_FILL    = 3'd4,
    ST_FIN     = 3'd5
  } state_t;

endpackage

// File: rtl/iram_boot_loader_if.sv
// Byte stream valid/ready handshake into the boot loader.
// master drives BYTE_IN/BYTE_VALID; slave drives BYTE_READY.
interface iram_boot_loader_if;

  logic [7:0] BYTE_IN;
  logic       BYTE_VALID;
  logic       BYTE_READY;

  modport master (
    output BYTE_IN,
    output BYTE_VALID,
    input  BYTE_READY
  );

  modport slave (
    input  BYTE_IN,
    input  BYTE_VALID,
    output BYTE_READY
  );

endinterface

// File: rtl/iram_byte_packer.sv
// Packs two stream bytes (hi first) into a 16-bit word.
// Ports: CLK, RESET, bs (byte stream slave), load_hi/load_lo
// (current loader phase), word, hi_taken, word_valid.
module iram_byte_packer (
  input  logic        CLK,
  input  logic        RESET,
  iram_boot_loader_if.slave bs,
  input  logic        load_hi,
  input  logic        load_lo,
  output logic [15:0] word,
  output logic        hi_taken,
  output logic        word_valid
);

  logic [7:0] hi;
  logic [7:0] lo;
  logic       xfer;

  assign bs.BYTE_READY = load_hi | load_lo;
  assign xfer = bs.BYTE_VALID & bs.BYTE_READY;

  assign hi_taken   = load_hi & xfer;
  // Low byte handshake completes the word for WRITE.
  assign word_valid = load_lo & xfer;
  assign word       = {hi, lo};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_taken)
        hi <= bs.BYTE_IN;
      if (word_valid)
        lo <= bs.BYTE_IN;
    end
  end

endmodule

// File: rtl/iram_boot_loader.sv
// Loads a byte-stream program image into the 128x16 IRAM,
// NOP-fills the rest, and muxes the IRAM port CPU/loader.
// Ports: CLK, RESET, START/LEN/ABORT control, bs byte
// stream, CPU fetch (CPU_ADDR/CPU_Q/CPU_STALL), IRAM port
// (IRAM_ADDR/WE/D/Q), status BUSY, DONE pulse, sticky ERR.
import iram_pkg::*;

module iram_boot_loader #(
  parameter int          ADDR_W      = IRAM_ADDR_W,
  parameter int          DEPTH_WORDS = IRAM_DEPTH_WORDS,
  parameter logic [15:0] NOP_WORD    = IRAM_NOP_WORD
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [7:0]        LEN,
  input  logic              ABORT,
  iram_boot_loader_if.slave bs,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  output logic [15:0]       CPU_Q,
  output logic              CPU_STALL,
  output logic [ADDR_W-1:0] IRAM_ADDR,
  output logic              IRAM_WE,
  output logic [15:0]       IRAM_D,
  input  logic [15:0]       IRAM_Q,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int WA_W  = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(DEPTH_WORDS + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);
  localparam logic [WA_W-1:0]  LAST_W  = WA_W'(DEPTH_WORDS - 1);

  state_t           state;
  state_t           state_n;
  logic [WA_W-1:0]  waddr;
  logic [WA_W-1:0]  waddr_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] len_c;
  logic [CNT_W-1:0] wnext;
  logic             err_n;
  logic             we;
  logic             done;
  logic [15:0]      word;
  logic             hi_taken;
  logic             word_valid;

  iram_byte_packer u_packer (
    .CLK        (CLK),
    .RESET      (RESET),
    .bs         (bs),
    .load_hi    (state == ST_LOAD_HI),
    .load_lo    (state == ST_LOAD_LO),
    .word       (word),
    .hi_taken   (hi_taken),
    .word_valid (word_valid)
  );

  assign len_c = (int'(LEN) > DEPTH_WORDS)
               ? DEPTH_C : CNT_W'(LEN);
  assign wnext = CNT_W'(waddr) + 1'b1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      waddr <= '0;
      count <= '0;
      ERR   <= 1'b0;
    end else begin
      state <= state_n;
      waddr <= waddr_n;
      count <= count_n;
      ERR   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    waddr_n = waddr;
    count_n = count;
    err_n   = ERR;
    we      = 1'b0;
    done    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (START) begin
          waddr_n = '0;
          count_n = len_c;
          err_n   = 1'b0;
          state_n = (len_c == '0)
                  ? ST_FILL : ST_LOAD_HI;
        end
      end
      ST_LOAD_HI: begin
        if (hi_taken)
          state_n = ST_LOAD_LO;
      end
      ST_LOAD_LO: begin
        if (word_valid)
          state_n = ST_WRITE;
      end
      ST_WRITE: begin
        we = 1'b1;
        if (wnext < count) begin
          waddr_n = waddr + 1'b1;
          state_n = ST_LOAD_HI;
        end else if (wnext < DEPTH_C) begin
          waddr_n = waddr + 1'b1;
          state_n = ST_FILL;
        end else begin
          state_n = ST_FIN;
        end
      end
      ST_FILL: begin
        we = 1'b1;
        if (waddr == LAST_W)
          state_n = ST_FIN;
        else
          waddr_n = waddr + 1'b1;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    // Abort cancels any write or completion this cycle.
    if (ABORT && state != ST_IDLE) begin
      state_n = ST_IDLE;
      waddr_n = waddr;
      err_n   = 1'b1;
      we      = 1'b0;
      done    = 1'b0;
    end
  end

  assign BUSY      = (state != ST_IDLE);
  assign CPU_STALL = BUSY;
  assign CPU_Q     = BUSY ? NOP_WORD : IRAM_Q;
  assign IRAM_ADDR = BUSY ? ADDR_W'({waddr, 1'b0})
                          : CPU_ADDR;
  assign IRAM_WE   = we;
  assign IRAM_D    = (state == ST_FILL) ? NOP_WORD : word;
  assign DONE      = done;

endmodule

// File: tb/tb_iram_boot_loader.sv
// Scoreboard bench for iram_boot_loader with an IRAM model.
// Expected writes are queued at stimulus time; a monitor pops them.
module tb_iram_boot_loader;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [7:0]  LEN = 8'd0;
  logic [7:0]  CPU_ADDR = 8'd0;
  logic [15:0] CPU_Q;
  logic        CPU_STALL;
  logic [7:0]  IRAM_ADDR;
  logic        IRAM_WE;
  logic [15:0] IRAM_D;
  logic [15:0] IRAM_Q;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  iram_boot_loader_if bif ();

  iram_boot_loader dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .LEN       (LEN),
    .ABORT     (ABORT),
    .bs        (bif),
    .CPU_ADDR  (CPU_ADDR),
    .CPU_Q     (CPU_Q),
    .CPU_STALL (CPU_STALL),
    .IRAM_ADDR (IRAM_ADDR),
    .IRAM_WE   (IRAM_WE),
    .IRAM_D    (IRAM_D),
    .IRAM_Q    (IRAM_Q),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  logic [15:0] mem [128];
  always @(posedge CLK)
    if (IRAM_WE) mem[IRAM_ADDR[7:1]] <= IRAM_D;
  assign IRAM_Q = mem[IRAM_ADDR[7:1]];

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] src[$];
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (DONE) done_cnt++;
    if (IRAM_WE) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {8'h0, IRAM_ADDR, IRAM_D}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", IRAM_ADDR, mon_e.a);
        chk("wr_data", IRAM_D, mon_e.d);
      end
    end
  end

  // vprob<0: BYTE_VALID toggles every other cycle.
  task automatic do_load(input int len, input int vprob,
                         input int abort_after, input int extra,
                         input bit fixed, input bit chk_stall,
                         output int busy_cyc, output int acc);
    int n, nw, cyc;
    bit done_seen, xfer;
    n = (len > 128) ? 128 : len;
    if (!fixed) begin
      src.delete();
      repeat (2 * n + extra) src.push_back(8'($urandom_range(0, 255)));
    end
    nw = (abort_after >= 0) ? abort_after / 2 : n;
    for (int i = 0; i < nw; i++)
      exp_q.push_back({8'(2 * i), src[2 * i], src[2 * i + 1]});
    if (abort_after < 0)
      for (int i = n; i < 128; i++)
        exp_q.push_back({8'(2 * i), 16'h0000});
    @(negedge CLK);
    START = 1'b1;
    LEN = 8'(len);
    @(negedge CLK);
    START = 1'b0;
    LEN = 8'($urandom_range(0, 255));
    chk("err_cleared", ERR, 0);
    acc = 0; cyc = 0; busy_cyc = 0; done_seen = 0;
    forever begin
      if (cyc > 6000) begin
        chk("load_timeout", 0, 1);
        break;
      end
      if (done_seen) begin
        chk("idle_after_done", BUSY, 0);
        chk("stall_released", CPU_STALL, 0);
        break;
      end
      if (chk_stall) begin
        chk("stall_held", CPU_STALL, 1);
        chk("cpu_q_nop", CPU_Q, 0);
      end
      if (DONE) begin
        done_seen = 1;
        busy_cyc = cyc + 1;
      end
      if (abort_after >= 0 && acc == abort_after) begin
        bif.BYTE_VALID = 1'b0;
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("abort_idle", BUSY, 0);
        chk("abort_err", ERR, 1);
        chk("abort_no_done", DONE, 0);
        break;
      end
      if (vprob < 0)
        bif.BYTE_VALID = (acc < src.size()) && cyc[0];
      else
        bif.BYTE_VALID = (acc < src.size()) &&
                         ($urandom_range(1, 100) <= vprob);
      bif.BYTE_IN = (acc < src.size()) ? src[acc] : 8'h00;
      xfer = bif.BYTE_VALID && bif.BYTE_READY;
      @(posedge CLK);
      if (xfer) acc++;
      @(negedge CLK);
      cyc++;
    end
    bif.BYTE_VALID = 1'b0;
    #1;
    chk("pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    int bc, acc, d0, len;
    bif.BYTE_VALID = 1'b0;
    bif.BYTE_IN = 8'h00;
    for (int i = 0; i < 128; i++) mem[i] = 16'hFFFF;
    mem[2] = 16'h5F7F;

    // Reset state and idle fetch passthrough
    repeat (2) @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_stall", CPU_STALL, 0);
    chk("rst_we", IRAM_WE, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_ready", bif.BYTE_READY, 0);
    RESET = 1'b0;
    CPU_ADDR = 8'h04;
    @(negedge CLK);
    chk("idle_fetch", CPU_Q, 16'h5F7F);
    chk("idle_stall", CPU_STALL, 0);
    chk("idle_ready", bif.BYTE_READY, 0);

    // Fixed two-word image, stream always valid
    src.delete();
    src.push_back(8'hF0); src.push_back(8'h01);
    src.push_back(8'h51); src.push_back(8'h7F);
    d0 = done_cnt;
    do_load(2, 100, -1, 0, 1, 1, bc, acc);
    chk("load_cycles", bc + 1, 1 + 6 + 126 + 1);
    chk("done_pulse", done_cnt - d0, 1);
    chk("accepted2", acc, 4);
    CPU_ADDR = 8'h02;
    @(negedge CLK);
    chk("read_w1", CPU_Q, 16'h517F);
    CPU_ADDR = 8'h00;
    @(negedge CLK);
    chk("read_w0", CPU_Q, 16'hF001);
    CPU_ADDR = 8'h10;
    @(negedge CLK);
    chk("read_fill", CPU_Q, 16'h0000);

    // Toggling valid, stall held
    d0 = done_cnt;
    do_load(1, -1, -1, 0, 0, 1, bc, acc);
    chk("toggle_acc", acc, 2);
    chk("toggle_done", done_cnt - d0, 1);

    // LEN=0: no bytes taken, full NOP fill
    d0 = done_cnt;
    do_load(0, 100, -1, 4, 0, 0, bc, acc);
    chk("len0_acc", acc, 0);
    chk("len0_cycles", bc, 129);
    chk("len0_done", done_cnt - d0, 1);

    // LEN=200 clamps to 128 words, no fill
    d0 = done_cnt;
    do_load(200, 100, -1, 4, 0, 0, bc, acc);
    chk("len200_acc", acc, 256);
    chk("len200_done", done_cnt - d0, 1);

    // Randomized lengths and stream gaps
    for (int k = 0; k < 4; k++) begin
      len = $urandom_range(0, 140);
      d0 = done_cnt;
      do_load(len, $urandom_range(30, 100), -1, 2, 0, 0, bc, acc);
      chk("rand_acc", acc, 2 * ((len > 128) ? 128 : len));
      chk("rand_done", done_cnt - d0, 1);
    end

    // Abort after hi byte of third word
    d0 = done_cnt;
    do_load(5, 100, 5, 0, 0, 0, bc, acc);
    repeat (3) @(negedge CLK);
    chk("abort_done_cnt", done_cnt - d0, 0);
    chk("abort_err_sticky", ERR, 1);
    do_load(0, 100, -1, 0, 0, 0, bc, acc);
    chk("err_after_start", ERR, 0);

    // Async reset in the middle of FILL
    for (int i = 0; i < 128; i++)
      exp_q.push_back({8'(2 * i), 16'h0000});
    @(negedge CLK);
    START = 1'b1;
    LEN = 8'd0;
    @(negedge CLK);
    START = 1'b0;
    repeat (20) @(negedge CLK);
    @(posedge CLK);
    #2;
    chk("pre_rst_we", IRAM_WE, 1);
    RESET = 1'b1;
    #1;
    chk("mid_rst_we", IRAM_WE, 0);
    chk("mid_rst_stall", CPU_STALL, 0);
    chk("mid_rst_busy", BUSY, 0);
    exp_q.delete();
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("post_rst_err", ERR, 0);
    chk("post_rst_busy", BUSY, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
